// File: rtl/wb_seq_ctrl.sv
// Weight/bias read sequencer and MAC strobe generator for the two-layer MNIST datapath.
// Optional abort input is enabled by defining WBSEQ_ABORT_EN.
//
// state      | meaning
// -----------+--------------------------------------------------------------
// S_IDLE     | waiting for start; all read/MAC strobes low
// S_L1_RD    | issuing [W1|b1] reads, ctr1 = 0..N_IN1
// S_L1_DRAIN | last layer-1 MAC (bias) in flight, no read issued
// S_L2_RD    | issuing [W2|b2] reads, ctr1 = 0..N_IN2
// S_L2_DRAIN | last layer-2 MAC (bias) in flight, run ends next edge
module wb_seq_ctrl #(
  parameter int N_IN1 = 784,
  parameter int N_IN2 = 32,
  parameter int AW    = 32
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          start,
`ifdef WBSEQ_ABORT_EN
  input  logic          abort,
`endif
  output logic [AW-1:0] ctr1,
  output logic          rd_en,
  output logic          rd_layer,
  output logic          mac_en,
  output logic          mac_layer,
  output logic          mac_first,
  output logic          mac_bias,
  output logic [AW-1:0] x_idx,
  output logic          l1_done,
  output logic          busy,
  output logic          done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_L1_RD,
    S_L1_DRAIN,
    S_L2_RD,
    S_L2_DRAIN
  } state_t;

  localparam logic [AW-1:0] LIM1 = AW'(N_IN1);
  localparam logic [AW-1:0] LIM2 = AW'(N_IN2);
  localparam logic [AW-1:0] ONE  = AW'(1);

  state_t state;
  logic   abort_req;

`ifdef WBSEQ_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= S_IDLE;
      ctr1      <= '0;
      rd_en     <= 1'b0;
      rd_layer  <= 1'b0;
      mac_en    <= 1'b0;
      mac_layer <= 1'b0;
      mac_first <= 1'b0;
      mac_bias  <= 1'b0;
      x_idx     <= '0;
      l1_done   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      // MAC stage trails the read stage by the memory's one-cycle read latency
      mac_en    <= rd_en;
      mac_layer <= rd_layer;
      x_idx     <= rd_en ? ctr1 : '0;
      mac_first <= rd_en && (ctr1 == '0);
      mac_bias  <= rd_en && (ctr1 == (rd_layer ? LIM2 : LIM1));
      l1_done   <= 1'b0;
      done      <= 1'b0;

      if (abort_req && (state != S_IDLE)) begin
        state     <= S_IDLE;
        ctr1      <= '0;
        rd_en     <= 1'b0;
        rd_layer  <= 1'b0;
        mac_en    <= 1'b0;
        mac_layer <= 1'b0;
        mac_first <= 1'b0;
        mac_bias  <= 1'b0;
        x_idx     <= '0;
        busy      <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              state    <= S_L1_RD;
              ctr1     <= '0;
              rd_en    <= 1'b1;
              rd_layer <= 1'b0;
              busy     <= 1'b1;
            end
          end
          S_L1_RD: begin
            if (ctr1 == LIM1) begin
              state <= S_L1_DRAIN;
              rd_en <= 1'b0;
              ctr1  <= '0;
            end else begin
              ctr1 <= ctr1 + ONE;
            end
          end
          S_L1_DRAIN: begin
            state    <= S_L2_RD;
            ctr1     <= '0;
            rd_en    <= 1'b1;
            rd_layer <= 1'b1;
            l1_done  <= 1'b1;
          end
          S_L2_RD: begin
            if (ctr1 == LIM2) begin
              state <= S_L2_DRAIN;
              rd_en <= 1'b0;
              ctr1  <= '0;
            end else begin
              ctr1 <= ctr1 + ONE;
            end
          end
          S_L2_DRAIN: begin
            state    <= S_IDLE;
            rd_layer <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b1;
          end
          default: begin
            state <= S_IDLE;
            rd_en <= 1'b0;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
